// File: rtl/blockram_system_v2_switch_debouncer.sv
// Slide-switch conditioner: per-bit synchroniser, stability-counter debouncer,
// committed-edge rise/fall pulses and a sticky change flag for software polling.
module blockram_system_v2_switch_debouncer #(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      SYNC_STAGES     = 2,
    parameter int unsigned      DEBOUNCE_CYCLES = 500000,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_debounced,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             changed,
    input  logic             changed_clr
);

    localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE,
        COUNT
    } state_e;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_w;
    state_e           state_q [WIDTH];
    logic [CW-1:0]    cnt_q   [WIDTH];
    logic [WIDTH-1:0] deb_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] commit_d;
    logic             changed_q;
    logic             changed_d;

    assign sync_w = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= RESET_VALUE;
            end
        end else begin
            sync_q[0] <= sw_raw;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // A bit commits when it has stayed different from the debounced level
    // for the full count window.
    always_comb begin
        commit_d = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            commit_d[i] = (state_q[i] == COUNT) && (sync_w[i] != deb_q[i]) &&
                          (cnt_q[i] == CNT_LAST);
        end
    end

    // A commit beats a simultaneous software clear so no change is ever lost.
    assign changed_d = (|commit_d) | (changed_q & ~changed_clr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            deb_q     <= RESET_VALUE;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            rise_q    <= commit_d & sync_w;
            fall_q    <= commit_d & ~sync_w;
            deb_q     <= (deb_q & ~commit_d) | (sync_w & commit_d);
            changed_q <= changed_d;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                case (state_q[i])
                    IDLE: begin
                        if (sync_w[i] != deb_q[i]) begin
                            cnt_q[i]   <= CW'(1);
                            state_q[i] <= COUNT;
                        end
                    end
                    COUNT: begin
                        if ((sync_w[i] == deb_q[i]) || commit_d[i]) begin
                            cnt_q[i]   <= '0;
                            state_q[i] <= IDLE;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + CW'(1);
                        end
                    end
                    default: begin
                        cnt_q[i]   <= '0;
                        state_q[i] <= IDLE;
                    end
                endcase
            end
        end
    end

    assign sw_debounced = deb_q;
    assign sw_rise      = rise_q;
    assign sw_fall      = fall_q;
    assign changed      = changed_q;

endmodule
